// File: rtl/note_seq_pkg.sv
// ============================================================================
// Module : note_seq_pkg
// Brief  : Shared state codes, song-entry layout and helpers for the sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package note_seq_pkg;

    localparam logic [1:0] S_RESET = 2'b00;
    localparam logic [1:0] S_LOAD  = 2'b01;
    localparam logic [1:0] S_START = 2'b10;
    localparam logic [1:0] S_PLAY  = 2'b11;

    localparam int DUR_W      = 4;
    localparam int DEF_FREQ_W = 11;

    typedef struct packed {
        logic                  en;
        logic [DEF_FREQ_W-1:0] freq;
    } ch_field_t;

    function automatic int entry_w(input int num_ch, input int freq_w);
        return DUR_W + num_ch * (1 + freq_w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/note_entry_decode.sv
// ============================================================================
// Module : note_entry_decode
// Brief  : Splits one song entry into note length, channel freqs and enables.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module note_entry_decode
    import note_seq_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FREQ_W     = 11,
    parameter int TICK_SHIFT = 18
) (
    input  logic [entry_w(NUM_CH, FREQ_W)-1:0] rom_data,
    output logic [23:0]                        length,
    output logic [NUM_CH*FREQ_W-1:0]           freq,
    output logic [NUM_CH-1:0]                  en
);

    localparam int ENTRY_W = entry_w(NUM_CH, FREQ_W);

    logic [DUR_W-1:0] w_dur;
    logic [23:0]      w_ticks;

    assign w_dur   = rom_data[ENTRY_W-1 -: DUR_W];
    assign w_ticks = 24'(w_dur) + 24'd1;
    // dur=15 at the largest shift gives 2^23, so 24 bits never overflow
    assign length  = w_ticks << TICK_SHIFT;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign freq[c*FREQ_W +: FREQ_W] = rom_data[c*(FREQ_W+1) +: FREQ_W];
        assign en[c]                    = rom_data[c*(FREQ_W+1) + FREQ_W];
    end

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// ============================================================================
// Module : note_sequencer
// Brief  : Walks the song ROM, feeding note length and channel controls.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FREQ_W     = 11,
    parameter int ADDR_W     = 8,
    parameter int SONG_LEN   = 256,
    parameter int TICK_SHIFT = 18
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [1:0]                         state,
    input  logic                               loop,
    output logic [ADDR_W-1:0]                  rom_addr,
    input  logic [entry_w(NUM_CH, FREQ_W)-1:0] rom_data,
    output logic [23:0]                        length,
    output logic [NUM_CH*FREQ_W-1:0]           ch_freq,
    output logic [NUM_CH-1:0]                  ch_en,
    output logic [NUM_CH-1:0]                  ch_trigger,
    output logic                               done
);

    localparam logic [23:0]       BASE_LEN  = 24'd1 << TICK_SHIFT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

    logic [23:0]               w_length;
    logic [NUM_CH*FREQ_W-1:0]  w_freq;
    logic [NUM_CH-1:0]         w_en;

    logic [ADDR_W-1:0]         r_addr;
    logic [23:0]               r_length;
    logic [NUM_CH*FREQ_W-1:0]  r_freq;
    logic [NUM_CH-1:0]         r_en;
    logic [NUM_CH-1:0]         r_trig;
    logic                      r_done;

    note_entry_decode #(
        .NUM_CH     (NUM_CH),
        .FREQ_W     (FREQ_W),
        .TICK_SHIFT (TICK_SHIFT)
    ) u_decode (
        .rom_data (rom_data),
        .length   (w_length),
        .freq     (w_freq),
        .en       (w_en)
    );

    always_ff @(posedge clk) begin
        if (!reset || state == S_RESET) begin
            r_addr   <= '0;
            r_length <= BASE_LEN;
            r_freq   <= '0;
            r_en     <= '0;
            r_trig   <= '0;
            r_done   <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    r_trig <= '0;
                    if (r_done) begin
                        // song over: play a silent base-length rest
                        r_en     <= '0;
                        r_length <= BASE_LEN;
                    end else begin
                        r_length <= w_length;
                        r_freq   <= w_freq;
                        r_en     <= w_en;
                        if (r_addr == LAST_ADDR) begin
                            if (loop) r_addr <= '0;
                            else      r_done <= 1'b1;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                end
                S_START: r_trig <= r_en;
                default: r_trig <= '0;
            endcase
        end
    end

    assign rom_addr   = r_addr;
    assign length     = r_length;
    assign ch_freq    = r_freq;
    assign ch_en      = r_en;
    assign ch_trigger = r_trig;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// ============================================================================
// Module : tb_note_sequencer
// Brief  : Random state-machine traffic on three configs vs. a note-level model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_note_sequencer;

    localparam int NK  = 3;
    localparam int NCH = 4;
    localparam int FW  = 11;
    localparam int EW  = 4 + NCH * (1 + FW);

    typedef struct packed {
        logic [3:0]           dur;
        logic [NCH-1:0]       en;
        logic [NCH-1:0][FW-1:0] freq;
    } note_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] state;
    logic       loop;

    logic [7:0]          rom_addr   [NK];
    logic [EW-1:0]       rom_data   [NK];
    logic [23:0]         length     [NK];
    logic [NCH*FW-1:0]   ch_freq    [NK];
    logic [NCH-1:0]      ch_en      [NK];
    logic [NCH-1:0]      ch_trigger [NK];
    logic                done       [NK];

    note_t rom [NK][4];

    int n_checks = 0;
    int n_fail   = 0;

    // model: where the song is and what each channel is doing
    int           m_idx  [NK];
    logic [23:0]  m_len  [NK];
    logic [FW-1:0] m_freq [NK][NCH];
    logic [NCH-1:0] m_en  [NK];
    logic [NCH-1:0] m_trig[NK];
    logic         m_done [NK];

    for (genvar k = 0; k < NK; k++) begin : g_dut
        note_sequencer #(
            .NUM_CH     (NCH),
            .FREQ_W     (FW),
            .ADDR_W     (8),
            .SONG_LEN   (k == 0 ? 4 : (k == 1 ? 2 : 3)),
            .TICK_SHIFT (k == 0 ? 18 : (k == 1 ? 19 : 0))
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .state      (state),
            .loop       (loop),
            .rom_addr   (rom_addr[k]),
            .rom_data   (rom_data[k]),
            .length     (length[k]),
            .ch_freq    (ch_freq[k]),
            .ch_en      (ch_en[k]),
            .ch_trigger (ch_trigger[k]),
            .done       (done[k])
        );
    end

    function automatic int song_len(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 2 : 3);
    endfunction

    function automatic int tick_shift(input int k);
        return (k == 0) ? 18 : ((k == 1) ? 19 : 0);
    endfunction

    function automatic logic [EW-1:0] pack_note(input note_t n);
        logic [EW-1:0] p;
        p[EW-1 -: 4] = n.dur;
        for (int c = 0; c < NCH; c++) p[c*(FW+1) +: FW+1] = {n.en[c], n.freq[c]};
        return p;
    endfunction

    // synchronous ROM, one cycle of read latency
    always @(posedge clk) begin
        for (int k = 0; k < NK; k++) rom_data[k] <= pack_note(rom[k][rom_addr[k][1:0]]);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rst_n, input logic [1:0] st, input bit lp);
        for (int k = 0; k < NK; k++) begin
            int base;
            base = 1 << tick_shift(k);
            if (!rst_n || st == 2'b00) begin
                m_idx[k]  = 0;
                m_len[k]  = 24'(base);
                m_en[k]   = '0;
                m_trig[k] = '0;
                m_done[k] = 1'b0;
                for (int c = 0; c < NCH; c++) m_freq[k][c] = '0;
            end else if (st == 2'b01) begin
                m_trig[k] = '0;
                if (m_done[k]) begin
                    m_en[k]  = '0;
                    m_len[k] = 24'(base);
                end else begin
                    note_t e;
                    e = rom[k][m_idx[k]];
                    m_len[k] = 24'((int'(e.dur) + 1) * base);
                    m_en[k]  = e.en;
                    for (int c = 0; c < NCH; c++) m_freq[k][c] = e.freq[c];
                    if (m_idx[k] == song_len(k) - 1) begin
                        if (lp) m_idx[k] = 0;
                        else    m_done[k] = 1'b1;
                    end else begin
                        m_idx[k] = m_idx[k] + 1;
                    end
                end
            end else if (st == 2'b10) begin
                m_trig[k] = m_en[k];
            end else begin
                m_trig[k] = '0;
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NK; k++) begin
            logic [NCH*FW-1:0] ef;
            for (int c = 0; c < NCH; c++) ef[c*FW +: FW] = m_freq[k][c];
            check($sformatf("k%0d.rom_addr", k),   64'(rom_addr[k]),   64'(m_idx[k]));
            check($sformatf("k%0d.length", k),     64'(length[k]),     64'(m_len[k]));
            check($sformatf("k%0d.ch_freq", k),    64'(ch_freq[k]),    64'(ef));
            check($sformatf("k%0d.ch_en", k),      64'(ch_en[k]),      64'(m_en[k]));
            check($sformatf("k%0d.ch_trigger", k), 64'(ch_trigger[k]), 64'(m_trig[k]));
            check($sformatf("k%0d.done", k),       64'(done[k]),       64'(m_done[k]));
        end
    endtask

    task automatic step(input bit rst_n, input logic [1:0] st, input bit lp);
        reset = rst_n;
        state = st;
        loop  = lp;
        model_step(rst_n, st, lp);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int r, hold, play_left;
        bit rst_n, lp;
        logic [1:0] st, prev;

        for (int k = 0; k < NK; k++) begin
            for (int a = 0; a < 4; a++) begin
                rom[k][a].dur = 4'($urandom);
                rom[k][a].en  = NCH'($urandom);
                for (int c = 0; c < NCH; c++) rom[k][a].freq[c] = FW'($urandom);
            end
        end
        rom[0][0] = '0;
        rom[0][0].dur     = 4'd3;
        rom[0][0].en      = 4'b0001;
        rom[0][0].freq[0] = 11'h5A3;
        rom[1][0].dur = 4'd15;
        rom[2][0].dur = 4'd0;

        reset = 1'b0;
        state = 2'b00;
        loop  = 1'b1;
        lp    = 1'b1;
        @(negedge clk);
        repeat (3) step(1'b0, 2'b00, lp);

        // one RESET cycle lets the ROM present entry 0 before the first LOAD
        hold      = 1;
        prev      = 2'b00;
        play_left = 0;
        for (int i = 0; i < 1500; i++) begin
            r     = $urandom_range(0, 99);
            rst_n = 1'b1;
            if ($urandom_range(0, 29) == 0) lp = ~lp;
            if (r < 2) begin
                rst_n = 1'b0;
                st    = 2'($urandom);
                hold  = 1;
            end else if (hold > 0) begin
                st = 2'b00;
                hold--;
            end else if (r < 4) begin
                st   = 2'b00;
                hold = 1;
            end else begin
                case (prev)
                    2'b00: st = 2'b01;
                    2'b01: st = 2'b10;
                    2'b10: begin
                        st        = 2'b11;
                        play_left = $urandom_range(1, 3);
                    end
                    default: begin
                        if (play_left > 1) begin
                            play_left--;
                            st = 2'b11;
                        end else begin
                            st = 2'b01;
                        end
                    end
                endcase
            end
            step(rst_n, st, lp);
            prev = rst_n ? st : 2'b00;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
